// File: rtl/qoi_memory_unit.sv
// qoi_memory_unit: shared byte RAM between the CPU (port A) and the QOI accelerator (port B), owner picked by sel.
// Define QOI_MEMU_ACCESS_ERR_EN to add the sticky err_o flag for non-owner accesses.
module qoi_memory_unit #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] data_a_i,
   output logic [DATA_W-1:0] data_a_o,
   input  logic              cs_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] data_b_i,
   output logic [DATA_W-1:0] data_b_o,
   input  logic              cs_b,
   input  logic              we_b,
   input  logic              sel,
`ifdef QOI_MEMU_ACCESS_ERR_EN
   output logic              flag_o,
   output logic              err_o
`else
   output logic              flag_o
`endif
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              sel_q;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              flag_set;
   logic              flag_clr;
   always_comb begin
      wr_en    = sel ? (cs_b & we_b) : (cs_a & we_a);
      wr_addr  = sel ? addr_b : addr_a;
      wr_data  = sel ? data_b_i : data_a_i;
      flag_set = !sel && cs_a && we_a && (&addr_a);
      flag_clr = sel && !sel_q;
   end
   // A write coinciding with reset assertion is dropped, RAM itself is never cleared
   always_ff @(posedge clk or negedge rst)
      if (rst && wr_en) mem[wr_addr] <= wr_data;
   // Owner writes leave data_o untouched; non-owner accesses force it to zero
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         data_a_o <= '0;
         data_b_o <= '0;
         flag_o   <= 1'b0;
         sel_q    <= 1'b0;
      end else begin
         sel_q <= sel;
         if (cs_a && !(!sel && we_a)) data_a_o <= sel ? '0 : mem[addr_a];
         if (cs_b && !(sel && we_b)) data_b_o <= sel ? mem[addr_b] : '0;
         if (flag_set) flag_o <= 1'b1;
         else if (flag_clr) flag_o <= 1'b0;
      end
`ifdef QOI_MEMU_ACCESS_ERR_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) err_o <= 1'b0;
      else if (sel ? cs_a : cs_b) err_o <= 1'b1;
`endif
endmodule

// File: tb/tb_qoi_memory_unit.sv
// tb_qoi_memory_unit: randomized scoreboard bench for qoi_memory_unit against a per-edge behavioural model.
module tb_qoi_memory_unit;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] addr_a = '0, data_a_i = '0, addr_b = '0, data_b_i = '0;
   logic [7:0] data_a_o, data_b_o;
   logic       cs_a = 1'b0, we_a = 1'b0, cs_b = 1'b0, we_b = 1'b0, sel = 1'b0;
   logic       flag_o;
`ifdef QOI_MEMU_ACCESS_ERR_EN
   logic       err_o;
`endif
   int total = 0;
   int bad = 0;

   typedef struct { logic [7:0] a; logic [7:0] b; logic f; logic e; } exp_t;
   exp_t q[$];

   // reference model state
   logic [7:0] m_mem [256];
   logic [7:0] m_a = '0, m_b = '0;
   logic       m_flag = 1'b0, m_prev_sel = 1'b0, m_err = 1'b0;

   qoi_memory_unit dut (
      .clk(clk), .rst(rst),
      .addr_a(addr_a), .data_a_i(data_a_i), .data_a_o(data_a_o), .cs_a(cs_a), .we_a(we_a),
      .addr_b(addr_b), .data_b_i(data_b_i), .data_b_o(data_b_o), .cs_b(cs_b), .we_b(we_b),
      .sel(sel),
`ifdef QOI_MEMU_ACCESS_ERR_EN
      .flag_o(flag_o), .err_o(err_o)
`else
      .flag_o(flag_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // One clock edge of the model, using the inputs the DUT saw at that edge
   task automatic model_step();
      exp_t e;
      if (cs_a) m_a = sel ? 8'h00 : (we_a ? m_a : m_mem[addr_a]);
      if (cs_b) m_b = !sel ? 8'h00 : (we_b ? m_b : m_mem[addr_b]);
      if (!sel && cs_a && we_a) m_mem[addr_a] = data_a_i;
      if (sel && cs_b && we_b) m_mem[addr_b] = data_b_i;
      if (!sel && cs_a && we_a && addr_a == 8'hFF) m_flag = 1'b1;
      else if (sel && !m_prev_sel) m_flag = 1'b0;
      m_prev_sel = sel;
      if (sel ? cs_a : cs_b) m_err = 1'b1;
      e.a = m_a; e.b = m_b; e.f = m_flag; e.e = m_err;
      q.push_back(e);
   endtask

   task automatic drive(input logic s, input logic ca, input logic wa, input logic [7:0] aa, input logic [7:0] da,
                        input logic cb, input logic wb, input logic [7:0] ab, input logic [7:0] db);
      sel = s; cs_a = ca; we_a = wa; addr_a = aa; data_a_i = da;
      cs_b = cb; we_b = wb; addr_b = ab; data_b_i = db;
      @(posedge clk);
      #1 model_step();
   endtask

   task automatic drive_random(input logic s);
      logic [7:0] aa, ab;
      aa = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      ab = 8'($urandom);
      drive(s, 1'($urandom), 1'($urandom), aa, 8'($urandom),
            1'($urandom), 1'($urandom), ab, 8'($urandom));
   endtask

   // monitor: compares DUT outputs to the queued expectation after each edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("data_a_o", data_a_o, e.a);
            check("data_b_o", data_b_o, e.b);
            check("flag_o", {7'd0, flag_o}, {7'd0, e.f});
`ifdef QOI_MEMU_ACCESS_ERR_EN
            check("err_o", {7'd0, err_o}, {7'd0, e.e});
`endif
         end
      end
   end

   initial begin
      #3;
      check("rst data_a_o", data_a_o, 8'h00);
      check("rst data_b_o", data_b_o, 8'h00);
      check("rst flag_o", {7'd0, flag_o}, 8'h00);
`ifdef QOI_MEMU_ACCESS_ERR_EN
      check("rst err_o", {7'd0, err_o}, 8'h00);
`endif
      #9 rst = 1'b1;
      // CPU fill with random non-owner noise on port B
      for (int i = 0; i < 256; i++)
         drive(1'b0, 1'b1, 1'b1, 8'(i), 8'(i), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      // handover: sel rises, B reads 0x10
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      // accelerator write seen by the CPU
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'hC5);
      drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      // non-owner blocked
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h05, 8'hAA);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00);
      drive(1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      // random traffic with sel bursts
      for (int i = 0; i < 400; i++) drive_random((i % 37) < 18 ? 1'b0 : 1'b1);
      for (int i = 0; i < 200; i++) drive_random(1'($urandom));
      // async reset mid-burst of B reads
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'(i + 8'h30), 8'h00);
      #2 rst = 1'b0;
      #1;
      check("async rst data_a_o", data_a_o, 8'h00);
      check("async rst data_b_o", data_b_o, 8'h00);
      check("async rst flag_o", {7'd0, flag_o}, 8'h00);
`ifdef QOI_MEMU_ACCESS_ERR_EN
      check("async rst err_o", {7'd0, err_o}, 8'h00);
`endif
      m_a = '0; m_b = '0; m_flag = 1'b0; m_prev_sel = 1'b0; m_err = 1'b0;
      cs_a = 1'b0; cs_b = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      // retention: sweep reads on both ports after reset
      for (int i = 0; i < 64; i++)
         drive(1'($urandom), 1'b1, 1'b0, 8'($urandom), 8'h00, 1'b1, 1'b0, 8'($urandom), 8'h00);
      repeat (3) @(posedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
